adder_share_ctrl: RTL and testbench

- Sequencer/arbiter that shares one 16-bit carry-lookahead adder instance (a, b -> sum, carry-out) between two requesters.
- Narrow ops take one adder pass.
- Wide 32-bit ops take three passes: low, high, and carry fix-up.
- Sits between ALU issue logic and the adder; the adder instance is external and wired to the add_* ports.

---
 rtl/adder_share_if.sv | 28 ++
 rtl/adder_share_ctrl.sv | 90 +++++++++
 tb/tb_adder_share_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_if.sv
// adder_share_if: request/response and shared-adder signals between ALU issue
// logic, the adder sequencer and the external 16-bit adder.
interface adder_share_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wide;
    logic [31:0] req_a0;
    logic [31:0] req_b0;
    logic [31:0] req_a1;
    logic [31:0] req_b1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_sum;
    logic        rsp_carry;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_carry;
    modport master (
        output req_valid, req_wide, req_a0, req_b0, req_a1, req_b1, rsp_ready, add_sum, add_carry,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, add_a, add_b
    );
    modport slave (
        input  req_valid, req_wide, req_a0, req_b0, req_a1, req_b1, rsp_ready, add_sum, add_carry,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, add_a, add_b
    );
endinterface

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: arbitrates two requesters onto one external 16-bit adder,
// sequencing 32-bit ops as low, high and carry fix-up passes.
module adder_share_ctrl #(
    parameter bit RR_ENABLE = 1'b1
) (
    input logic          clk,
    input logic          rst,
    adder_share_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;
    state_t      state;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [15:0] lo;
    logic [15:0] hi_tmp;
    logic        wide;
    logic        id;
    logic        ptr;
    logic        c0;
    logic        c_hi;
    logic        win;
    logic        fire;
    always_comb begin
        win = (RR_ENABLE && bus.req_valid == 2'b11) ? ptr : ~bus.req_valid[0];
        bus.req_ready = (!rst && state == IDLE && bus.req_valid != 2'b00) ? 2'b01 << win : 2'b00;
        fire = |(bus.req_valid & bus.req_ready);
        bus.add_a = state == LO ? opa[15:0] : state == HI ? opa[31:16] : state == FIX ? hi_tmp : 16'h0;
        bus.add_b = state == LO ? opb[15:0] : state == HI ? opb[31:16] : state == FIX ? {15'h0, c0} : 16'h0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            opa           <= '0;
            opb           <= '0;
            lo            <= '0;
            hi_tmp        <= '0;
            wide          <= 1'b0;
            id            <= 1'b0;
            ptr           <= 1'b0;
            c0            <= 1'b0;
            c_hi          <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_carry <= 1'b0;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    opa   <= win ? bus.req_a1 : bus.req_a0;
                    opb   <= win ? bus.req_b1 : bus.req_b0;
                    wide  <= bus.req_wide[win];
                    id    <= win;
                    ptr   <= RR_ENABLE ? ~win : 1'b0;
                    state <= LO;
                end
                LO: begin
                    lo <= bus.add_sum;
                    c0 <= bus.add_carry;
                    if (wide) begin
                        state <= HI;
                    end else begin
                        bus.rsp_sum   <= {16'h0, bus.add_sum};
                        bus.rsp_carry <= bus.add_carry;
                        bus.rsp_id    <= id;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                HI: begin
                    hi_tmp <= bus.add_sum;
                    c_hi   <= bus.add_carry;
                    state  <= FIX;
                end
                FIX: begin
                    // the low-half carry can ripple out only when the high half did not
                    bus.rsp_sum   <= {bus.add_sum, lo};
                    bus.rsp_carry <= c_hi | bus.add_carry;
                    bus.rsp_id    <= id;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: directed and random checks of the shared-adder sequencer
// against an arithmetic reference model and a round-robin priority model.
module tb_adder_share_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   ptr_m = 0;
    adder_share_if bus();
    adder_share_if bus2();
    always #5 clk = ~clk;
    assign {bus.add_carry, bus.add_sum}   = 17'(bus.add_a) + 17'(bus.add_b);
    assign {bus2.add_carry, bus2.add_sum} = 17'(bus2.add_a) + 17'(bus2.add_b);
    adder_share_ctrl #(.RR_ENABLE(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    adder_share_ctrl #(.RR_ENABLE(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int win_of(input logic [1:0] m);
        return m == 2'b11 ? ptr_m : (m[0] ? 0 : 1);
    endfunction

    // one complete transaction on the round-robin instance, starting and ending at a negedge in IDLE
    task automatic do_op(input logic [1:0] mask, input logic [1:0] w, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1, input int hold);
        int          win;
        int          cnt;
        logic [1:0]  g;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] s;
        logic [31:0] esum;
        logic        ecarry;
        win = win_of(mask);
        a = win == 1 ? a1 : a0;
        b = win == 1 ? b1 : b0;
        if (w[win]) begin
            s = 33'(a) + 33'(b);
            esum = s[31:0];
            ecarry = s[32];
        end else begin
            s = 33'(a[15:0]) + 33'(b[15:0]);
            esum = {16'h0, s[15:0]};
            ecarry = s[16];
        end
        bus.req_valid = mask;
        bus.req_wide = w;
        bus.req_a0 = a0;
        bus.req_b0 = b0;
        bus.req_a1 = a1;
        bus.req_b1 = b1;
        bus.rsp_ready = 1'b0;
        g = 2'b00;
        for (int i = 0; i < 20 && g == 2'b00; i++) begin
            #1 g = bus.req_ready;
            if (g == 2'b00) @(negedge clk);
        end
        chk("grant", g, 2'b01 << win);
        if (g == 2'b00) begin
            bus.req_valid = 2'b00;
            return;
        end
        @(posedge clk);
        ptr_m = 1 - win;
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.req_a0 = $urandom;
        bus.req_b0 = $urandom;
        bus.req_a1 = $urandom;
        bus.req_b1 = $urandom;
        cnt = 1;
        while (!bus.rsp_valid && cnt < 12) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("latency", cnt, w[win] ? 4 : 2);
        chk("rsp_sum", bus.rsp_sum, esum);
        chk("rsp_carry", bus.rsp_carry, ecarry);
        chk("rsp_id", bus.rsp_id, win);
        if (hold > 0) bus.req_valid = mask;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1'b1);
            chk("bp_sum", bus.rsp_sum, esum);
            chk("bp_id", bus.rsp_id, win);
            chk("bp_ready", bus.req_ready, 2'b00);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_done", bus.rsp_valid, 1'b0);
        if (hold > 0) chk("resume_grant", bus.req_ready, 2'b01 << win_of(mask));
        bus.req_valid = 2'b00;
    endtask

    initial begin
        int n;
        logic [31:0] ta;
        logic [31:0] tb;
        bus.req_valid = 2'b11;
        bus.req_wide = 2'b00;
        bus.req_a0 = '0;
        bus.req_b0 = '0;
        bus.req_a1 = '0;
        bus.req_b1 = '0;
        bus.rsp_ready = 1'b0;
        bus2.req_valid = 2'b00;
        bus2.req_wide = 2'b00;
        bus2.req_a0 = '0;
        bus2.req_b0 = '0;
        bus2.req_a1 = '0;
        bus2.req_b1 = '0;
        bus2.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_rsp_sum", bus.rsp_sum, 32'h0);
        chk("rst_rsp_carry", bus.rsp_carry, 1'b0);
        chk("rst_add_a", bus.add_a, 16'h0);
        chk("rst_add_b", bus.add_b, 16'h0);
        bus.req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);
        // narrow carry, then narrow with junk in the ignored upper halves
        do_op(2'b01, 2'b00, 32'h0000FFFF, 32'h00000001, 32'h0, 32'h0, 0);
        do_op(2'b01, 2'b00, 32'hABCDFFFF, 32'h12340001, 32'h0, 32'h0, 0);
        // wide ops exercising the cross-half carry
        do_op(2'b10, 2'b10, 32'h0, 32'h0, 32'h0000FFFF, 32'h00000001, 0);
        do_op(2'b10, 2'b10, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000001, 0);
        do_op(2'b10, 2'b10, 32'h0, 32'h0, 32'h80000000, 32'h80000000, 0);
        // backpressure with both requesters waiting
        do_op(2'b11, 2'b00, 32'h00001234, 32'h0000F000, 32'h00005555, 32'h00002222, 3);
        // reset in the fix-up pass of a wide op
        ta = 32'h1234FFFF;
        tb = 32'h00010001;
        bus.req_valid = 2'b10;
        bus.req_wide = 2'b10;
        bus.req_a1 = ta;
        bus.req_b1 = tb;
        #1 chk("mid_grant", bus.req_ready, 2'b10);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("fix_add_a", bus.add_a, 16'(ta[31:16] + tb[31:16]));
        chk("fix_add_b", bus.add_b, 16'h1);
        rst = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk("abort_add_a", bus.add_a, 16'h0);
        chk("abort_add_b", bus.add_b, 16'h0);
        chk("abort_req_ready", bus.req_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        ptr_m = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rsp_after_abort", bus.rsp_valid, 1'b0);
        end
        do_op(2'b10, 2'b00, 32'h0, 32'h0, 32'h00000007, 32'h00000009, 0);
        // round-robin: both requesters held, response always accepted
        bus.req_wide = 2'b00;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                chk("rr_grant", bus.req_ready, ptr_m == 1 ? 2'b10 : 2'b01);
                chk("rr_cycle", c, 3 * n);
                ptr_m = 1 - ptr_m;
                n++;
            end
            @(negedge clk);
        end
        chk("rr_count", n, 5);
        bus.req_valid = 2'b00;
        repeat (4) @(negedge clk);
        bus.rsp_ready = 1'b0;
        // fixed priority instance: req0 keeps winning
        bus2.req_valid = 2'b11;
        bus2.rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (bus2.req_ready != 2'b00) begin
                chk("fp_grant", bus2.req_ready, 2'b01);
                chk("fp_cycle", c, 3 * n);
                n++;
            end
            @(negedge clk);
        end
        chk("fp_count", n, 3);
        bus2.req_valid = 2'b00;
        repeat (4) @(negedge clk);
        // random sweep
        for (int i = 0; i < 1000; i++) begin
            do_op(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 2)));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
